mac_booth_radix4_acc: RTL and testbench
=======================================

MAC_BOOTH_RADIX4_ACC -- requirements
Module: mac_booth_radix4_acc

Interface
REQ-001 SHALL have parameter MUL_LEN, default 24, meaning operand width; must be even and >= 4.
REQ-002 SHALL have parameter ACC_LEN, default 56, meaning accumulator width; must be >= 2*MUL_LEN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation request is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have ports a and b, input, MUL_LEN bits each: the multiplicand and the multiplier.
REQ-008 SHALL have port signed_mode, input, 1 bit: 1 = a and b are two's complement, 0 = unsigned.
REQ-009 SHALL have port acc_clr, input, 1 bit: 1 = the accumulation base for this operation is zero.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port product, output, 2*MUL_LEN bits: the product of the last operation.
REQ-013 SHALL have port acc, output, ACC_LEN bits: the running accumulator.
REQ-014 SHALL have port acc_ovf, output, 1 bit: sticky accumulator overflow flag.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid and in_ready are both high on a clk edge.
REQ-018 SHALL, on acceptance, latch a, b, signed_mode and acc_clr. Each operand is extended to MUL_LEN+2 bits: sign-extended if signed_mode=1, zero-extended otherwise. b gets an appended b[-1]=0. The FSM enters RUN with the digit counter at 0.
REQ-019 SHALL process one radix-4 Booth digit per RUN cycle, DIGITS = MUL_LEN/2+1, with digit codes {-2,-1,0,+1,+2}.
REQ-020 SHALL form each partial product as a two's-complement multiple of the extended a, shifted by 2*i, and fold it into a sum/carry carry-save pair. Sum, carry and partial product are 2*MUL_LEN+2 bits.
REQ-021 SHALL, on the edge that processes digit DIGITS-1, do all of the following together:
- perform one carry-propagate add of the sum/carry pair;
- register product = low 2*MUL_LEN bits of that add;
- register acc = base + ext(product), where base = 0 if the latched acc_clr=1, else the current acc, and ext is sign-extension if the latched signed_mode=1, else zero-extension;
- set out_valid=1 and enter DONE.
REQ-022 SHALL give a latency of exactly DIGITS clk edges from the accept edge to out_valid=1 (13 for MUL_LEN=24).
REQ-023 SHALL, in DONE, hold out_valid, product and acc stable until out_ready=1. On that edge out_valid goes to 0 and the FSM returns to IDLE, so the next accept is possible one edge later.
REQ-024 SHALL ignore in_valid, a, b, signed_mode and acc_clr outside IDLE; their changes in RUN/DONE do not affect the result.
REQ-025 SHALL set acc_ovf when the REQ-021 accumulate overflows. Overflow is signed overflow if the latched signed_mode=1, else unsigned carry-out of ACC_LEN.
REQ-026 SHALL clear acc_ovf to 0 when an operation with latched acc_clr=1 completes, unless that same accumulate itself overflows.
REQ-027 SHALL keep product, acc and acc_ovf unchanged in IDLE and RUN except as stated in REQ-021, REQ-025 and REQ-026.

Reset
REQ-028 SHALL, while rst=1 (asynchronously), force:
- the FSM to IDLE;
- the digit counter, sum/carry, product, acc and acc_ovf to 0;
- out_valid=0, busy=0, in_ready=0.
REQ-029 SHALL abort any in-flight RUN or DONE operation on reset without producing out_valid. in_ready=1 SHALL follow on the first edge after rst deasserts.

Configuration
REQ-030 SHALL, when MAC_BOOTH_ACC_SAT_EN is defined, saturate acc on overflow instead of wrapping:
- signed: to 2^(ACC_LEN-1)-1 (positive overflow) or -2^(ACC_LEN-1) (negative overflow);
- unsigned: to 2^ACC_LEN-1.
acc_ovf SHALL still be set.
REQ-031 SHALL, when MAC_BOOTH_ACC_SAT_EN is undefined, wrap acc modulo 2^ACC_LEN, with acc_ovf set per REQ-025.

Verification
REQ-032 SHALL cover an unsigned full-scale multiply: MUL_LEN=24, signed_mode=0, acc_clr=1, a=b=0xFFFFFF. Required: product=0xFFFFFE000001, acc=0x00FFFFFE000001, out_valid exactly 13 edges after accept.
REQ-033 SHALL cover signed products: signed_mode=1, acc_clr=1.
- a=b=0xFFFFFF (-1): required product=0x000000000001.
- Next, a=b=0x800000: required product=0x400000000000.
REQ-034 SHALL cover accumulation: 3*5 with acc_clr=1, then 2*7 with acc_clr=0, then 0xFFFFFE*0x000004 signed with acc_clr=0. Required acc: 15, then 29, then 21.
REQ-035 SHALL cover backpressure: out_ready held 0 for 10 cycles after out_valid. Required: out_valid, product and acc stable; in_ready=0; in_valid pulses ignored; on out_ready=1, IDLE on the next edge.
REQ-036 SHALL cover reset mid-operation: assert rst at RUN digit 6. Required: all outputs 0 immediately, no out_valid, and a fresh 3*5 with acc_clr=0 afterwards gives acc=15.
REQ-037 SHALL cover overflow: ACC_LEN=48, signed, 0x800000*0x800000 twice (acc_clr=1, then 0). Required: acc_ovf=1, with acc=0x7FFFFFFFFFFF if MAC_BOOTH_ACC_SAT_EN is defined, else 0x800000000000.

Source files
------------

// File: rtl/mac_booth_radix4_acc.sv
// Radix-4 Booth multiply-accumulate unit: one Booth digit per cycle into a carry-save pair, final add and accumulate.
// Optional macro MAC_BOOTH_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module mac_booth_radix4_acc #(
    parameter int unsigned MUL_LEN = 24,
    parameter int unsigned ACC_LEN = 56
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MUL_LEN-1:0]     a,
    input  logic [MUL_LEN-1:0]     b,
    input  logic                   signed_mode,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*MUL_LEN-1:0]   product,
    output logic [ACC_LEN-1:0]     acc,
    output logic                   acc_ovf,
    output logic                   busy
);

    localparam int unsigned PW     = 2 * MUL_LEN + 2;
    localparam int unsigned RW     = 2 * MUL_LEN;
    localparam int unsigned BW     = MUL_LEN + 3;
    localparam int unsigned DIGITS = MUL_LEN / 2 + 1;
    localparam int unsigned CW     = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [BW-1:0]   mplr;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   carry;
    logic            sgn_q;
    logic            clr_q;

    logic [PW-1:0]      pp;
    logic [PW-1:0]      sum_n;
    logic [PW-1:0]      carry_n;
    logic [RW-1:0]      fin;
    logic [ACC_LEN-1:0] base;
    logic [ACC_LEN-1:0] pext;
    logic [ACC_LEN:0]   asum;
    logic [ACC_LEN-1:0] acc_n;
    logic               ovf_n;

    // Booth digit select from the low three multiplier bits; mcand already carries the 2*i shift
    always_comb begin
        pp = '0;
        case (mplr[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = ~(mcand << 1) + PW'(1);
            3'b101, 3'b110: pp = ~mcand + PW'(1);
            default:        pp = '0;
        endcase
        sum_n   = sum ^ carry ^ pp;
        carry_n = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
        fin     = RW'(sum_n) + RW'(carry_n);
    end

    // Accumulate with overflow detection; the base sign picks the saturation direction
    always_comb begin
        base  = clr_q ? '0 : acc;
        pext  = sgn_q ? ACC_LEN'($signed(fin)) : ACC_LEN'(fin);
        asum  = {1'b0, base} + {1'b0, pext};
        ovf_n = sgn_q ? ((base[ACC_LEN-1] == pext[ACC_LEN-1]) && (asum[ACC_LEN-1] != base[ACC_LEN-1]))
                      : asum[ACC_LEN];
        acc_n = asum[ACC_LEN-1:0];
`ifdef MAC_BOOTH_ACC_SAT_EN
        if (ovf_n) begin
            if (!sgn_q)
                acc_n = '1;
            else if (base[ACC_LEN-1])
                acc_n = {1'b1, {(ACC_LEN-1){1'b0}}};
            else
                acc_n = {1'b0, {(ACC_LEN-1){1'b1}}};
        end
`else
        acc_n = asum[ACC_LEN-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            sum       <= '0;
            carry     <= '0;
            sgn_q     <= 1'b0;
            clr_q     <= 1'b0;
            product   <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        mcand    <= signed_mode ? PW'($signed(a)) : PW'(a);
                        mplr     <= {(signed_mode ? {2{b[MUL_LEN-1]}} : 2'b00), b, 1'b0};
                        sgn_q    <= signed_mode;
                        clr_q    <= acc_clr;
                        cnt      <= '0;
                        sum      <= '0;
                        carry    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum   <= sum_n;
                    carry <= carry_n;
                    mcand <= mcand << 2;
                    mplr  <= mplr >> 2;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DIGITS - 1)) begin
                        product   <= fin;
                        acc       <= acc_n;
                        acc_ovf   <= clr_q ? ovf_n : (acc_ovf | ovf_n);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_booth_radix4_acc.sv
// Self-checking bench for mac_booth_radix4_acc: directed cases plus random operations against an arithmetic model.
module tb_mac_booth_radix4_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        signed_mode;
    logic        acc_clr;
    logic        out_ready;
    logic [23:0] a;
    logic [23:0] b;

    logic        in_ready, out_valid, acc_ovf, busy;
    logic [47:0] product;
    logic [55:0] acc;

    logic        in_ready2, out_valid2, acc_ovf2, busy2;
    logic [47:0] product2;
    logic [47:0] acc2;

    int checks = 0;
    int errors = 0;

    logic [55:0] m_acc;
    logic        m_ovf;
    logic [47:0] m_prod;
    logic [23:0] spec_v [4];

    localparam logic signed [63:0] SMAX  = 64'sh007F_FFFF_FFFF_FFFF;
    localparam logic signed [63:0] SMIN  = 64'shFF80_0000_0000_0000;
    localparam logic signed [63:0] ULIM  = 64'sh0100_0000_0000_0000;

    mac_booth_radix4_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .acc(acc), .acc_ovf(acc_ovf), .busy(busy)
    );

    mac_booth_radix4_acc #(.MUL_LEN(24), .ACC_LEN(48)) dut48 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .signed_mode(signed_mode), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .product(product2),
        .acc(acc2), .acc_ovf(acc_ovf2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product and accumulate, overflow judged on the true sum
    task automatic model_op(input logic [23:0] ma, input logic [23:0] mb, input bit sgn, input bit clr);
        logic signed [63:0] pa, pb, full, pv, bv, tv;
        logic [63:0] tb_bits;
        logic        ovf;
        logic [55:0] res;
        pa     = sgn ? {{40{ma[23]}}, ma} : {40'd0, ma};
        pb     = sgn ? {{40{mb[23]}}, mb} : {40'd0, mb};
        full   = pa * pb;
        m_prod = full[47:0];
        pv     = sgn ? {{16{m_prod[47]}}, m_prod} : {16'd0, m_prod};
        bv     = clr ? 64'sd0 : (sgn ? {{8{m_acc[55]}}, m_acc} : {8'd0, m_acc});
        tv     = bv + pv;
        ovf    = sgn ? ((tv > SMAX) || (tv < SMIN)) : (tv >= ULIM);
        tb_bits = tv;
        res    = tb_bits[55:0];
`ifdef MAC_BOOTH_ACC_SAT_EN
        if (ovf)
            res = sgn ? ((tv > 0) ? 56'h7F_FFFF_FFFF_FFFF : 56'h80_0000_0000_0000) : {56{1'b1}};
`endif
        m_acc = res;
        m_ovf = clr ? ovf : (m_ovf | ovf);
    endtask

    task automatic run_op(input logic [23:0] oa, input logic [23:0] ob, input bit sgn, input bit clr, input int hold);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        a = oa; b = ob; signed_mode = sgn; acc_clr = clr; in_valid = 1'b1;
        model_op(oa, ob, sgn, clr);
        @(posedge clk);
        @(negedge clk);
        check("busy_run", 64'(busy), 64'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            a = 24'($urandom); b = 24'($urandom);
            signed_mode = 1'($urandom); acc_clr = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency", 64'(n), 64'd13);
        check("product", 64'(product), 64'(m_prod));
        check("acc", 64'(acc), 64'(m_acc));
        check("acc_ovf", 64'(acc_ovf), 64'(m_ovf));
        repeat (hold) begin
            in_valid = 1'b1; a = 24'($urandom); b = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_product", 64'(product), 64'(m_prod));
            check("hold_acc", 64'(acc), 64'(m_acc));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_in_ready", 64'(in_ready), 64'd1);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        spec_v[0] = 24'h000000; spec_v[1] = 24'hFFFFFF;
        spec_v[2] = 24'h800000; spec_v[3] = 24'h7FFFFF;
        rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b0; a = '0; b = '0;
        m_acc = '0; m_ovf = 1'b0; m_prod = '0;

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_acc", 64'(acc), 64'd0);
        check("rst_acc_ovf", 64'(acc_ovf), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_in_ready_held", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Unsigned full scale
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 0);
        check("fs_product", 64'(product), 64'h0000_FFFF_FE00_0001);
        check("fs_acc", 64'(acc), 64'h00FF_FFFE_0000_01);

        // Signed products
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 0);
        check("sgn_m1_product", 64'(product), 64'h1);
        run_op(24'h800000, 24'h800000, 1'b1, 1'b1, 0);
        check("sgn_min_product", 64'(product), 64'h4000_0000_0000);

        // Accumulation chain
        run_op(24'd3, 24'd5, 1'b0, 1'b1, 0);
        check("chain_acc_15", 64'(acc), 64'd15);
        run_op(24'd2, 24'd7, 1'b0, 1'b0, 0);
        check("chain_acc_29", 64'(acc), 64'd29);
        run_op(24'hFFFFFE, 24'h000004, 1'b1, 1'b0, 0);
        check("chain_acc_21", 64'(acc), 64'd21);

        // Backpressure
        run_op(24'h123456, 24'h00ABCD, 1'b0, 1'b0, 10);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [23:0] ra, rb;
            ra = ($urandom_range(3) == 0) ? spec_v[$urandom_range(3)] : 24'($urandom);
            rb = ($urandom_range(3) == 0) ? spec_v[$urandom_range(3)] : 24'($urandom);
            run_op(ra, rb, 1'($urandom), ($urandom_range(3) == 0),
                   ($urandom_range(7) == 0) ? int'($urandom_range(3)) : 0);
        end

        // Reset in the middle of RUN at digit 6
        a = 24'h123456; b = 24'h654321; signed_mode = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_product", 64'(product), 64'd0);
        check("mid_rst_acc", 64'(acc), 64'd0);
        check("mid_rst_acc_ovf", 64'(acc_ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_acc = '0; m_ovf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("post_abort_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(24'd3, 24'd5, 1'b0, 1'b0, 0);
        check("post_abort_acc_15", 64'(acc), 64'd15);

        // Signed overflow on the 48-bit accumulator instance
        run_op(24'h800000, 24'h800000, 1'b1, 1'b1, 0);
        check("ovf48_first_acc", 64'(acc2), 64'h4000_0000_0000);
        check("ovf48_first_flag", 64'(acc_ovf2), 64'd0);
        run_op(24'h800000, 24'h800000, 1'b1, 1'b0, 0);
        check("ovf48_flag", 64'(acc_ovf2), 64'd1);
`ifdef MAC_BOOTH_ACC_SAT_EN
        check("ovf48_acc", 64'(acc2), 64'h7FFF_FFFF_FFFF);
`else
        check("ovf48_acc", 64'(acc2), 64'h8000_0000_0000);
`endif
        // A fresh clearing operation without overflow drops the sticky flag
        run_op(24'd1, 24'd1, 1'b1, 1'b1, 0);
        check("ovf48_clear", 64'(acc_ovf2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
